tmds_sync_extract: RTL and testbench

//  Recovers video timing from channel-0 (blue) 10-bit TMDS symbols coming out of the

---
 rtl/tmds_sync_extract_if.sv | 24 ++
 rtl/tmds_sync_extract.sv | 263 ++++++++++++++++++++++++++
 tb/tb_tmds_sync_extract.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/tmds_sync_extract_if.sv
// Channel-0 symbol input and recovered timing / measurement outputs.
// master: symbol source and timing consumer; slave: the extractor.
interface tmds_sync_extract_if;
  logic        valid;
  logic [9:0]  sym;
  logic        vsync_inv;
  logic        pvalid_o;
  logic        vsync_o;
  logic        hsync_o;
  logic        frame_keep;
  logic [11:0] width;
  logic [11:0] height;
  logic        meas_valid;

  modport master (
    output valid, sym, vsync_inv,
    input  pvalid_o, vsync_o, hsync_o, frame_keep, width, height, meas_valid
  );

  modport slave (
    input  valid, sym, vsync_inv,
    output pvalid_o, vsync_o, hsync_o, frame_keep, width, height, meas_valid
  );
endinterface

// File: rtl/tmds_sync_extract.sv
// Video timing recovery from channel-0 TMDS symbols.
// Stage 1 decodes the symbol, runs the blank/armed/active FSM, debounces
// control tokens into vsync/hsync, decides frame keep/drop and measures the
// active width/height. ALIGN_DLY flops then line the result up with the
// colour pipeline.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_BLANK  | blanking or invalid input; counting guard-band symbols
//  ST_ARMED  | enough guard-band seen; next non-GB, non-control is pixel
//  ST_ACTIVE | active video; every non-control symbol is a pixel
module tmds_sync_extract #(
  parameter int ALIGN_DLY = 12,
  parameter int RUN_CTL   = 4,
  parameter int RUN_GB    = 2,
  parameter int FRAME_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  tmds_sync_extract_if.slave bus
);

  localparam logic [9:0]  SYM_C00   = 10'b1101010100;
  localparam logic [9:0]  SYM_C01   = 10'b0010101011;
  localparam logic [9:0]  SYM_C10   = 10'b0101010100;
  localparam logic [9:0]  SYM_C11   = 10'b1010101011;
  localparam logic [9:0]  SYM_GB    = 10'b1011001100;
  localparam logic [3:0]  RUN_CTL_C = 4'(RUN_CTL);
  localparam logic [3:0]  RUN_GB_C  = 4'(RUN_GB);
  localparam logic [3:0]  FDIV_M1   = 4'(FRAME_DIV - 1);
  localparam logic [11:0] CNT_MAX   = 12'hFFF;

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  typedef struct packed {
    logic        pvalid;
    logic        vsync;
    logic        hsync;
    logic        keep;
    logic        meas;
    logic [11:0] width;
    logic [11:0] height;
  } out_t;

  state_t      state_q, state_d;
  logic [3:0]  gb_run_q, gb_run_d;
  logic [3:0]  ctl_run_q, ctl_run_d;
  logic [1:0]  tok_q, tok_d;
  logic        vs_q, vs_d;
  logic        hs_q, hs_d;
  logic        inv_q;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [11:0] pcnt_q, pcnt_d;
  logic [11:0] lcnt_q, lcnt_d;
  logic [11:0] last_w_q, last_w_d;
  logic [11:0] width_q, width_d;
  logic [11:0] height_q, height_d;
  out_t        s1_q, s1_d;
  out_t        out_w;

  logic        is_ctl;
  logic        is_gb;
  logic [1:0]  tok;
  logic        same_tok;
  logic        reach;
  logic        vs_edge;
  logic        pixel;
  logic        line_end;
  logic        keep;
  logic [3:0]  gb_inc;

  // Classify the incoming symbol: control token with its {vs,hs}, or guard band.
  always_comb begin
    is_ctl = 1'b1;
    tok    = 2'b00;
    case (bus.sym)
      SYM_C00: tok = 2'b00;
      SYM_C01: tok = 2'b01;
      SYM_C10: tok = 2'b10;
      SYM_C11: tok = 2'b11;
      default: is_ctl = 1'b0;
    endcase
    is_gb = (bus.sym == SYM_GB);
  end

  // Next-state for FSM, sync debounce, frame drop and measurement counters.
  always_comb begin
    state_d  = state_q;
    gb_run_d = gb_run_q;
    ctl_run_d = ctl_run_q;
    tok_d    = tok_q;
    vs_d     = vs_q;
    hs_d     = hs_q;
    fcnt_d   = fcnt_q;
    pcnt_d   = pcnt_q;
    lcnt_d   = lcnt_q;
    last_w_d = last_w_q;
    width_d  = width_q;
    height_d = height_q;
    same_tok = 1'b0;
    reach    = 1'b0;
    vs_edge  = 1'b0;
    pixel    = 1'b0;
    gb_inc   = gb_run_q;

    if (!bus.valid) begin
      state_d   = ST_BLANK;
      gb_run_d  = '0;
      ctl_run_d = '0;
    end else begin
      // A completed run only updates sync once; staying saturated on the
      // same token is not a new completion.
      if (is_ctl) begin
        same_tok = (ctl_run_q != 4'd0) && (tok == tok_q);
        if (same_tok) begin
          if (ctl_run_q < RUN_CTL_C) ctl_run_d = ctl_run_q + 4'd1;
        end else begin
          ctl_run_d = 4'd1;
        end
        tok_d = tok;
        reach = (ctl_run_d == RUN_CTL_C) && !(same_tok && (ctl_run_q == RUN_CTL_C));
      end else begin
        ctl_run_d = '0;
      end

      case (state_q)
        ST_BLANK: begin
          if (is_gb) begin
            if (gb_run_q < RUN_GB_C) gb_inc = gb_run_q + 4'd1;
            if (gb_inc == RUN_GB_C) begin
              state_d  = ST_ARMED;
              gb_run_d = '0;
            end else begin
              gb_run_d = gb_inc;
            end
          end else begin
            gb_run_d = '0;
          end
        end
        ST_ARMED: begin
          gb_run_d = '0;
          if (is_ctl) begin
            state_d = ST_BLANK;
          end else if (!is_gb) begin
            state_d = ST_ACTIVE;
            pixel   = 1'b1;
          end
        end
        ST_ACTIVE: begin
          gb_run_d = '0;
          if (is_ctl) state_d = ST_BLANK;
          else        pixel   = 1'b1;
        end
        default: begin
          state_d  = ST_BLANK;
          gb_run_d = '0;
        end
      endcase
    end

    line_end = (state_q == ST_ACTIVE) && (state_d == ST_BLANK);

    if (pixel && (pcnt_q != CNT_MAX)) pcnt_d = pcnt_q + 12'd1;
    if (line_end) begin
      last_w_d = pcnt_q;
      if (lcnt_q != CNT_MAX) lcnt_d = lcnt_q + 12'd1;
      pcnt_d = '0;
    end

    if (reach) begin
      vs_d = tok[1] ^ inv_q;
      hs_d = tok[0];
    end
    vs_edge = reach && vs_d && !vs_q;

    // Measurement is taken from the "next" line values so a line that ends on
    // the very symbol of the edge (RUN_CTL=1) is still counted.
    if (vs_edge) begin
      fcnt_d   = (fcnt_q == FDIV_M1) ? 4'd0 : fcnt_q + 4'd1;
      width_d  = last_w_d;
      height_d = lcnt_d;
      lcnt_d   = '0;
    end

    keep = (fcnt_d == 4'd0);

    s1_d.pvalid = pixel & keep;
    s1_d.vsync  = vs_d & keep;
    s1_d.hsync  = hs_d;
    s1_d.keep   = keep;
    s1_d.meas   = vs_edge;
    s1_d.width  = width_d;
    s1_d.height = height_d;
  end

  // Stage-1 state and raw results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_BLANK;
      gb_run_q  <= '0;
      ctl_run_q <= '0;
      tok_q     <= '0;
      vs_q      <= 1'b0;
      hs_q      <= 1'b0;
      inv_q     <= 1'b0;
      fcnt_q    <= '0;
      pcnt_q    <= '0;
      lcnt_q    <= '0;
      last_w_q  <= '0;
      width_q   <= '0;
      height_q  <= '0;
      s1_q      <= '0;
    end else begin
      state_q   <= state_d;
      gb_run_q  <= gb_run_d;
      ctl_run_q <= ctl_run_d;
      tok_q     <= tok_d;
      vs_q      <= vs_d;
      hs_q      <= hs_d;
      inv_q     <= bus.vsync_inv;
      fcnt_q    <= fcnt_d;
      pcnt_q    <= pcnt_d;
      lcnt_q    <= lcnt_d;
      last_w_q  <= last_w_d;
      width_q   <= width_d;
      height_q  <= height_d;
      s1_q      <= s1_d;
    end
  end

  generate
    if (ALIGN_DLY == 0) begin : g_nodly
      assign out_w = s1_q;
    end else begin : g_dly
      out_t dly_q [ALIGN_DLY];

      // Alignment delay line behind stage 1.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < ALIGN_DLY; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= s1_q;
          for (int i = 1; i < ALIGN_DLY; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign out_w = dly_q[ALIGN_DLY-1];
    end
  endgenerate

  assign bus.pvalid_o   = out_w.pvalid;
  assign bus.vsync_o    = out_w.vsync;
  assign bus.hsync_o    = out_w.hsync;
  assign bus.frame_keep = out_w.keep;
  assign bus.meas_valid = out_w.meas;
  assign bus.width      = out_w.width;
  assign bus.height     = out_w.height;

endmodule

// File: tb/tb_tmds_sync_extract.sv
// Directed bench: a table of symbols with hand-derived expected outputs,
// compared 13 cycles later, plus a mid-frame reset sequence.
module tb_tmds_sync_extract;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] GB  = 10'b1011001100;
  localparam logic [9:0] PX  = 10'h0F0;
  localparam int         LAT = 13;

  typedef struct {
    logic        v;
    logic [9:0]  s;
    logic        inv;
    logic        pv;
    logic        vs;
    logic        hs;
    logic        kp;
    logic        ms;
    logic [11:0] w;
    logic [11:0] h;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[$];

  tmds_sync_extract_if bus();

  tmds_sync_extract #(
    .ALIGN_DLY(12),
    .RUN_CTL  (4),
    .RUN_GB   (2),
    .FRAME_DIV(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s idx=%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input int n, input logic v, input logic [9:0] s, input logic inv,
                     input logic pv, input logic vs, input logic hs, input logic kp,
                     input logic ms, input logic [11:0] w, input logic [11:0] h);
    vec_t r;
    r.v = v; r.s = s; r.inv = inv; r.pv = pv; r.vs = vs; r.hs = hs;
    r.kp = kp; r.ms = ms; r.w = w; r.h = h;
    repeat (n) vecs.push_back(r);
  endtask

  // One line: 4x ctl00, 2x GB, 8 pixels, 4x ctl01 (hsync asserted on 4th ctl01).
  task automatic line(input logic kp, input logic vso3, input logic hs3,
                      input logic [11:0] w, input logic [11:0] h);
    add(3, 1, C00, 0, 0,  vso3, hs3, kp, 0, w, h);
    add(1, 1, C00, 0, 0,  0,    0,   kp, 0, w, h);
    add(2, 1, GB,  0, 0,  0,    0,   kp, 0, w, h);
    add(8, 1, PX,  0, kp, 0,    0,   kp, 0, w, h);
    add(3, 1, C01, 0, 0,  0,    0,   kp, 0, w, h);
    add(1, 1, C01, 0, 0,  0,    1,   kp, 0, w, h);
  endtask

  // Vsync: 4x ctl10; the 4th completes the run, rises vsync and reports 8x3.
  task automatic vsy(input logic kold, input logic knew,
                     input logic [11:0] w, input logic [11:0] h);
    add(3, 1, C10, 0, 0, 0,    1, kold, 0, w,     h);
    add(1, 1, C10, 0, 0, knew, 0, knew, 1, 12'd8, 12'd3);
  endtask

  task automatic step(input logic v, input logic [9:0] s);
    bus.valid = v;
    bus.sym   = s;
    @(negedge clk);
  endtask

  initial begin
    int total;
    int cnt;

    bus.valid = 1'b0;
    bus.sym   = C00;
    bus.vsync_inv = 1'b0;

    // Reset then idle blanking
    add(8, 1, C00, 0, 0, 0, 0, 1, 0, 12'd0, 12'd0);
    // Frame 0 (kept)
    line(1, 0, 0, 12'd0, 12'd0);
    line(1, 0, 1, 12'd0, 12'd0);
    line(1, 0, 1, 12'd0, 12'd0);
    vsy(1, 0, 12'd0, 12'd0);
    // Frame 1 (dropped)
    line(0, 0, 0, 12'd8, 12'd3);
    line(0, 0, 1, 12'd8, 12'd3);
    line(0, 0, 1, 12'd8, 12'd3);
    vsy(0, 1, 12'd8, 12'd3);
    // Frame 2 (kept)
    line(1, 1, 0, 12'd8, 12'd3);
    line(1, 0, 1, 12'd8, 12'd3);
    line(1, 0, 1, 12'd8, 12'd3);
    vsy(1, 0, 12'd8, 12'd3);
    // Frame 3 (dropped)
    line(0, 0, 0, 12'd8, 12'd3);
    line(0, 0, 1, 12'd8, 12'd3);
    line(0, 0, 1, 12'd8, 12'd3);
    vsy(0, 1, 12'd8, 12'd3);
    // Glitches: short ctl10 run, single GB then pixels
    add(3, 1, C00, 0, 0, 1, 0, 1, 0, 12'd8, 12'd3);
    add(1, 1, C00, 0, 0, 0, 0, 1, 0, 12'd8, 12'd3);
    add(3, 1, C10, 0, 0, 0, 0, 1, 0, 12'd8, 12'd3);
    add(1, 1, C00, 0, 0, 0, 0, 1, 0, 12'd8, 12'd3);
    add(3, 1, C00, 0, 0, 0, 0, 1, 0, 12'd8, 12'd3);
    add(1, 1, GB,  0, 0, 0, 0, 1, 0, 12'd8, 12'd3);
    add(3, 1, PX,  0, 0, 0, 0, 1, 0, 12'd8, 12'd3);
    add(1, 1, C00, 0, 0, 0, 0, 1, 0, 12'd8, 12'd3);
    // valid drop mid-active, pixels only after fresh guard band
    add(2, 1, GB,  0, 0, 0, 0, 1, 0, 12'd8, 12'd3);
    add(3, 1, PX,  0, 1, 0, 0, 1, 0, 12'd8, 12'd3);
    add(2, 0, GB,  0, 0, 0, 0, 1, 0, 12'd8, 12'd3);
    add(3, 1, PX,  0, 0, 0, 0, 1, 0, 12'd8, 12'd3);
    add(2, 1, GB,  0, 0, 0, 0, 1, 0, 12'd8, 12'd3);
    add(2, 1, PX,  0, 1, 0, 0, 1, 0, 12'd8, 12'd3);
    add(4, 1, C00, 0, 0, 0, 0, 1, 0, 12'd8, 12'd3);
    // Inverted vsync: ctl00 completion is now the rising edge
    add(2, 1, C00, 1, 0, 0, 0, 1, 0, 12'd8, 12'd3);
    add(4, 1, C10, 1, 0, 0, 0, 1, 0, 12'd8, 12'd3);
    add(3, 1, C00, 1, 0, 0, 0, 1, 0, 12'd8, 12'd3);
    add(1, 1, C00, 1, 0, 0, 0, 0, 1, 12'd2, 12'd2);
    add(3, 1, C00, 1, 0, 0, 0, 0, 0, 12'd2, 12'd2);
    add(2, 1, GB,  1, 0, 0, 0, 0, 0, 12'd2, 12'd2);
    add(5, 1, PX,  1, 0, 0, 0, 0, 0, 12'd2, 12'd2);
    add(3, 1, C10, 1, 0, 0, 0, 0, 0, 12'd2, 12'd2);
    add(1, 1, C10, 1, 0, 0, 0, 0, 0, 12'd2, 12'd2);
    add(3, 1, C00, 1, 0, 0, 0, 0, 0, 12'd2, 12'd2);
    add(1, 1, C00, 1, 0, 1, 0, 1, 1, 12'd5, 12'd1);
    add(3, 1, C00, 1, 0, 1, 0, 1, 0, 12'd5, 12'd1);

    total = vecs.size();

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int j = 0; j < total + LAT; j++) begin
      if (j < LAT) begin
        chk("reset_zero", j, {3'b0, bus.pvalid_o, bus.vsync_o, bus.hsync_o, bus.frame_keep,
                              bus.meas_valid, bus.width, bus.height}, 32'd0);
      end else begin
        chk("pvalid",     j - LAT, {31'b0, bus.pvalid_o},   {31'b0, vecs[j-LAT].pv});
        chk("vsync",      j - LAT, {31'b0, bus.vsync_o},    {31'b0, vecs[j-LAT].vs});
        chk("hsync",      j - LAT, {31'b0, bus.hsync_o},    {31'b0, vecs[j-LAT].hs});
        chk("frame_keep", j - LAT, {31'b0, bus.frame_keep}, {31'b0, vecs[j-LAT].kp});
        chk("meas_valid", j - LAT, {31'b0, bus.meas_valid}, {31'b0, vecs[j-LAT].ms});
        chk("width",      j - LAT, {20'b0, bus.width},      {20'b0, vecs[j-LAT].w});
        chk("height",     j - LAT, {20'b0, bus.height},     {20'b0, vecs[j-LAT].h});
      end
      if (j < total) begin
        bus.valid     = vecs[j].v;
        bus.sym       = vecs[j].s;
        bus.vsync_inv = vecs[j].inv;
      end else begin
        bus.valid = 1'b1;
        bus.sym   = C00;
      end
      @(negedge clk);
    end

    // Mid-frame reset: one finished line and a partial line are discarded.
    bus.vsync_inv = 1'b0;
    step(1, GB); step(1, GB);
    repeat (3) step(1, PX);
    step(1, C01);
    step(1, GB); step(1, GB);
    repeat (2) step(1, PX);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset", 0, {3'b0, bus.pvalid_o, bus.vsync_o, bus.hsync_o, bus.frame_keep,
                         bus.meas_valid, bus.width, bus.height}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, GB); step(1, GB);
    repeat (4) step(1, PX);
    repeat (4) step(1, C10);
    cnt = 0;
    while (!bus.meas_valid && cnt < 30) begin
      step(1, C10);
      cnt++;
    end
    chk("post_rst_latency", 0, cnt, 12);
    chk("post_rst_width",   0, {20'b0, bus.width},  32'd4);
    chk("post_rst_height",  0, {20'b0, bus.height}, 32'd1);
    chk("post_rst_keep",    0, {31'b0, bus.frame_keep}, 32'd0);
    chk("post_rst_vsync",   0, {31'b0, bus.vsync_o},    32'd0);
    step(1, C10);
    chk("meas_one_cycle",   0, {31'b0, bus.meas_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
